// File: rtl/br_write_arbiter.sv
// br_write_arbiter: owns the single write port of the register file.
// After reset, or on a clr_start pulse, it sweeps zeros into every register.
// Outside the sweep it round-robin arbitrates between requester A (ALU
// writeback) and requester B (memory-load writeback). WriteReg, WriteData
// and RegWrite are registered and drive the register file directly.
//
// Optional build macro: ZERO_REG_PROTECT_EN
//   When defined, a requester write to address 0 still completes the
//   handshake, but RegWrite is suppressed. The clear sweep still writes
//   register 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_CLEAR | zero-clear sweep, one register per cycle; requesters stalled
// ST_ARB   | round-robin arbitration of the write port between A and B

module br_write_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              clr_start,
    output logic              busy,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    // 1: B won the most recent tie, so A wins the next one.
    logic                last_grant_b_q, last_grant_b_d;
    logic                reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic [CNT_W-1:0]    conflict_q, conflict_d;

    logic                xfer;
    logic [ADDR_W-1:0]   xfer_addr;
    logic [DATA_W-1:0]   xfer_data;
    logic                xfer_commit;

    // Next-state, grant and write-port decode.
    always_comb begin
        state_d        = state_q;
        clr_idx_d      = clr_idx_q;
        last_grant_b_d = last_grant_b_q;
        reg_write_d    = 1'b0;
        write_reg_d    = write_reg_q;
        write_data_d   = write_data_q;
        conflict_d     = conflict_q;
        a_ready        = 1'b0;
        b_ready        = 1'b0;
        xfer           = 1'b0;
        xfer_addr      = '0;
        xfer_data      = '0;
        xfer_commit    = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                reg_write_d  = 1'b1;
                write_reg_d  = clr_idx_q;
                write_data_d = '0;
                clr_idx_d    = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = ST_ARB;
                end
            end

            ST_ARB: begin
                // Counted even when a clear request pre-empts the grant.
                if (a_valid && b_valid && (conflict_q != '1)) begin
                    conflict_d = conflict_q + 1'b1;
                end

                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end else begin
                    if (a_valid && b_valid) begin
                        // Pointer only moves on a tie, so a lone grant does
                        // not steal the next tie from the other side.
                        a_ready        = last_grant_b_q;
                        b_ready        = !last_grant_b_q;
                        last_grant_b_d = !last_grant_b_q;
                    end else begin
                        a_ready = a_valid;
                        b_ready = b_valid;
                    end

                    if (a_ready) begin
                        xfer      = 1'b1;
                        xfer_addr = a_addr;
                        xfer_data = a_data;
                    end else if (b_ready) begin
                        xfer      = 1'b1;
                        xfer_addr = b_addr;
                        xfer_data = b_data;
                    end

`ifdef ZERO_REG_PROTECT_EN
                    xfer_commit = xfer && (xfer_addr != '0);
`else
                    xfer_commit = xfer;
`endif
                    if (xfer_commit) begin
                        reg_write_d  = 1'b1;
                        write_reg_d  = xfer_addr;
                        write_data_d = xfer_data;
                    end
                end
            end

            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // State and write-port registers; reset restarts the sweep from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_CLEAR;
            clr_idx_q      <= '0;
            last_grant_b_q <= 1'b1;
            reg_write_q    <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
            conflict_q     <= '0;
        end else begin
            state_q        <= state_d;
            clr_idx_q      <= clr_idx_d;
            last_grant_b_q <= last_grant_b_d;
            reg_write_q    <= reg_write_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
            conflict_q     <= conflict_d;
        end
    end

    assign busy         = (state_q == ST_CLEAR);
    assign RegWrite     = reg_write_q;
    assign WriteReg     = write_reg_q;
    assign WriteData    = write_data_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_br_write_arbiter.sv
// Directed testbench for br_write_arbiter. The counter is built narrow so
// saturation is reachable in a short run. Honours ZERO_REG_PROTECT_EN.

module tb_br_write_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              clr_start;
    logic              busy;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [CNT_W-1:0]  conflict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    br_write_arbiter #(
        .NUM_REGS (32),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .clr_start    (clr_start),
        .busy         (busy),
        .WriteReg     (WriteReg),
        .WriteData    (WriteData),
        .RegWrite     (RegWrite),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects the first sweep write to appear on the next edge.
    task automatic check_sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            check_eq({tag, "_busy"}, 32'(busy), 32'd1);
            check_eq({tag, "_ardy"}, 32'(a_ready), 32'd0);
            check_eq({tag, "_brdy"}, 32'(b_ready), 32'd0);
            tick();
            check_eq({tag, "_we"},   32'(RegWrite), 32'd1);
            check_eq({tag, "_addr"}, 32'(WriteReg), 32'(i));
            check_eq({tag, "_data"}, WriteData, 32'd0);
        end
        check_eq({tag, "_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic exp_we0;
        logic [ADDR_W-1:0] exp_addr0;

        rst_n = 1'b0; clr_start = 1'b0;
        a_valid = 1'b1; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;

        // Reset values, with a request held to show ready is gated.
        #12;
        check_eq("rst_we",   32'(RegWrite), 32'd0);
        check_eq("rst_addr", 32'(WriteReg), 32'd0);
        check_eq("rst_data", WriteData, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_cnt",  32'(conflict_cnt), 32'd0);
        check_eq("rst_ardy", 32'(a_ready), 32'd0);
        a_valid = 1'b0;

        // Sweep after reset release.
        @(posedge clk); #2;
        rst_n = 1'b1;
        check_sweep("sweep0");

        // Idle ARB cycle: RegWrite drops, address/data hold.
        tick();
        check_eq("idle_we",   32'(RegWrite), 32'd0);
        check_eq("idle_addr", 32'(WriteReg), 32'd31);

        // Single A write.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        check_eq("a1_ardy", 32'(a_ready), 32'd1);
        check_eq("a1_brdy", 32'(b_ready), 32'd0);
        tick();
        a_valid = 1'b0;
        check_eq("a1_we",   32'(RegWrite), 32'd1);
        check_eq("a1_addr", 32'(WriteReg), 32'd5);
        check_eq("a1_data", WriteData, 32'hDEADBEEF);
        tick();
        check_eq("a1_idle_we",   32'(RegWrite), 32'd0);
        check_eq("a1_idle_data", WriteData, 32'hDEADBEEF);

        // Both valid for 4 cycles: A, B, A, B.
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("rr_ardy", 32'(a_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("rr_brdy", 32'(b_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            check_eq("rr_we",   32'(RegWrite), 32'd1);
            check_eq("rr_addr", 32'(WriteReg), (k % 2 == 0) ? 32'd3 : 32'd4);
            check_eq("rr_data", WriteData, (k % 2 == 0) ? 32'h33 : 32'h44);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check_eq("rr_cnt", 32'(conflict_cnt), 32'd4);

        // Same address from both: A first (B won last tie), then B persists.
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hA1;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hB2;
        #1;
        check_eq("same_ardy", 32'(a_ready), 32'd1);
        check_eq("same_brdy", 32'(b_ready), 32'd0);
        tick();
        a_valid = 1'b0;
        check_eq("same_a_data", WriteData, 32'hA1);
        #1;
        check_eq("same_brdy2", 32'(b_ready), 32'd1);
        tick();
        b_valid = 1'b0;
        check_eq("same_b_addr", 32'(WriteReg), 32'd7);
        check_eq("same_b_data", WriteData, 32'hB2);
        check_eq("same_cnt", 32'(conflict_cnt), 32'd5);

        // 13 more conflict cycles: 5+13 saturates a 4-bit counter at 15.
        a_valid = 1'b1; b_valid = 1'b1;
        for (int k = 0; k < 13; k++) tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check_eq("sat_cnt", 32'(conflict_cnt), 32'd15);

        // Clear request pre-empts a pending B write.
        clr_start = 1'b1;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
        #1;
        check_eq("clr_brdy", 32'(b_ready), 32'd0);
        tick();
        clr_start = 1'b0;
        check_eq("clr_we", 32'(RegWrite), 32'd0);
        check_sweep("sweep1");
        check_eq("clr_brdy_after", 32'(b_ready), 32'd1);
        tick();
        b_valid = 1'b0;
        check_eq("clr_b_addr", 32'(WriteReg), 32'd9);
        check_eq("clr_b_data", WriteData, 32'h99);
        check_eq("clr_cnt", 32'(conflict_cnt), 32'd15);

        // clr_start inside a sweep is ignored; reset at clr_idx=17 aborts it.
        clr_start = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) tick();
        check_eq("ign_addr", 32'(WriteReg), 32'd9);
        tick();
        clr_start = 1'b0;
        check_eq("ign_addr2", 32'(WriteReg), 32'd10);
        for (int k = 0; k < 6; k++) tick();
        check_eq("mid_addr", 32'(WriteReg), 32'd16);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_we",   32'(RegWrite), 32'd0);
        check_eq("mid_rst_addr", 32'(WriteReg), 32'd0);
        check_eq("mid_rst_cnt",  32'(conflict_cnt), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        check_sweep("sweep2");

        // Write to register 0.
`ifdef ZERO_REG_PROTECT_EN
        exp_we0 = 1'b0; exp_addr0 = 5'd31;
`else
        exp_we0 = 1'b1; exp_addr0 = 5'd0;
`endif
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1;
        #1;
        check_eq("z0_ardy", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        check_eq("z0_we",   32'(RegWrite), 32'(exp_we0));
        check_eq("z0_addr", 32'(WriteReg), 32'(exp_addr0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
